phase_countdown_bcd: RTL
========================

PHASE_COUNTDOWN_BCD -- requirements
Module: phase_countdown_bcd

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of countdown display channels (NS, EW, ...).
REQ-002 SHALL have parameter TIME_W, default 8, width of the binary time value.
REQ-003 SHALL have parameter DIGITS, default 2, number of BCD digits per channel.
REQ-004 SHALL have parameter FLASH_TH, default 3, flash threshold in seconds.
REQ-005 SHALL have parameter LZ_BLANK, default 1, enabling leading-zero blanking.
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port in_valid, input, 1, update request.
REQ-009 SHALL have port in_ready, output, 1, converter idle and able to accept.
REQ-010 SHALL have port in_ch, input, CH_W=max(1,clog2(NUM_CH)), target channel.
REQ-011 SHALL have port in_value, input, TIME_W, binary seconds.
REQ-012 SHALL have port in_en, input, 1, channel shown (0 = blank channel).
REQ-013 SHALL have port flash_tick, input, 1, single-cycle flash-rate pulse.
REQ-014 SHALL have port bcd_out, output, NUM_CH*DIGITS*4, BCD digits; channel c digit d (d=0 ones) at bits [(c*DIGITS+d)*4 +: 4].
REQ-015 SHALL have port blank_out, output, NUM_CH*DIGITS, per-digit blank mask, same indexing.
REQ-016 SHALL have port ovf_out, output, NUM_CH, per-channel saturation flag.
REQ-017 SHALL have port upd_done, output, 1, one-cycle pulse when a channel's outputs change.

Function
REQ-018 SHALL implement FSM IDLE -> SHIFT -> COMMIT -> IDLE; in_ready=1 only in IDLE.
REQ-019 SHALL accept when in_valid&in_ready in cycle T: latch in_ch, in_en, value; go to SHIFT.
REQ-020 SHALL stay in SHIFT exactly TIME_W cycles running one double-dabble step per cycle (add 3 to each nibble >=5, then shift left 1).
REQ-021 SHALL in COMMIT write the selected channel's digits/ovf/en and assert upd_done; new outputs visible after edge T+TIME_W+1 (in_valid-to-output latency TIME_W+2 cycles).
REQ-022 SHALL saturate: value > 10^DIGITS-1 -> all digits 9, ovf=1; else ovf=0.
REQ-023 SHALL ignore in_valid while in_ready=0; no queueing; requester holds in_valid until accepted.
REQ-024 SHALL ignore an accepted in_ch >= NUM_CH: full conversion runs, no output changes, upd_done stays 0.
REQ-025 SHALL on accepted in_en=0 store digits 0, ovf 0, and blank every digit of that channel.
REQ-026 SHALL when LZ_BLANK=1 blank digit d>0 if it and all higher digits are zero; ones digit never leading-blanked.
REQ-027 SHALL toggle flash_phase on each flash_tick cycle, independent of FSM state.
REQ-028 SHALL blank all digits of an enabled channel when flash_phase=1 and stored value in [1, FLASH_TH]; value 0 or > FLASH_TH never flashes.
REQ-029 SHALL derive blank_out combinationally from stored registers and flash_phase; bcd_out unaffected by blanking.
REQ-030 SHALL leave channels not selected by a commit unchanged.

Reset
REQ-031 SHALL on rst: FSM IDLE, in_ready 1 from next cycle, bcd_out 0, ovf_out 0, upd_done 0, flash_phase 0, all channels disabled (blank_out all 1).
REQ-032 SHALL abort any in-flight conversion on rst without committing; rst overrides simultaneous in_valid and flash_tick.

Verification
REQ-033 Defaults: accept ch0 value 57 en 1 -> after 10 cycles bcd ch0 = 5,7, ovf 0, upd_done one pulse, ch1 unchanged.
REQ-034 Saturation: ch1 value 150 -> ch1 digits 9,9, ovf_out[1]=1; then value 99 -> ovf_out[1]=0.
REQ-035 Flash: ch0 value 3, two flash_ticks -> ch0 blank 11 then 00; value 4 -> never blanked; value 0 -> tens blanked only.
REQ-036 Backpressure: in_valid held during SHIFT with new value 12 -> in_ready 0, accepted in IDLE cycle, second commit 12.
REQ-037 Reset mid-SHIFT with value 88 -> no upd_done, outputs at reset values, in_ready 1 next cycle.

Source files
------------

// File: rtl/phase_countdown_bcd.sv
// phase_countdown_bcd: per-channel binary-to-BCD countdown display with saturation,
// leading-zero blanking and low-value flashing, one serial double-dabble converter shared by all channels.
module phase_countdown_bcd #(
   parameter int NUM_CH = 2,
   parameter int TIME_W = 8,
   parameter int DIGITS = 2,
   parameter int FLASH_TH = 3,
   parameter int LZ_BLANK = 1,
   localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [CH_W-1:0]            in_ch,
   input  logic [TIME_W-1:0]          in_value,
   input  logic                       in_en,
   input  logic                       flash_tick,
   output logic [NUM_CH*DIGITS*4-1:0] bcd_out,
   output logic [NUM_CH*DIGITS-1:0]   blank_out,
   output logic [NUM_CH-1:0]          ovf_out,
   output logic                       upd_done
);
   localparam int DW = DIGITS * 4;
   localparam int CNT_W = $clog2(TIME_W + 1);
   localparam logic [63:0] MAXV = 64'(10 ** DIGITS - 1);
   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
   state_t state, state_n;
   logic [DW-1:0] bcd_sh, adj, digits;
   logic [TIME_W-1:0] bin_sh, val_q;
   logic [CH_W-1:0] ch_q;
   logic [CNT_W-1:0] cnt;
   logic [NUM_CH-1:0] en_r, lo_r, sel;
   logic en_q, sat, lo, z, flash_phase;
   always_ff @(posedge clk) state <= rst ? IDLE : state_n;
   always_comb begin
      in_ready = state == IDLE;
      state_n = state == IDLE ? (in_valid ? SHIFT : IDLE) :
                state == SHIFT ? (cnt == CNT_W'(TIME_W - 1) ? COMMIT : SHIFT) : IDLE;
   end
   // Values too large for the display lose their top digits in the converter, so they are forced to all nines.
   always_comb begin
      adj = bcd_sh;
      for (int d = 0; d < DIGITS; d++)
         adj[d*4 +: 4] = bcd_sh[d*4 +: 4] >= 4'd5 ? bcd_sh[d*4 +: 4] + 4'd3 : bcd_sh[d*4 +: 4];
      sat = 64'(val_q) > MAXV;
      lo = !sat && val_q != '0 && 64'(val_q) <= 64'(FLASH_TH);
      digits = !en_q ? '0 : sat ? {DIGITS{4'd9}} : bcd_sh;
      for (int c = 0; c < NUM_CH; c++)
         sel[c] = state == COMMIT && ch_q == CH_W'(c);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         bcd_out <= '0;
         ovf_out <= '0;
         en_r <= '0;
         lo_r <= '0;
         upd_done <= 1'b0;
         cnt <= '0;
         bcd_sh <= '0;
         bin_sh <= '0;
         val_q <= '0;
         ch_q <= '0;
         en_q <= 1'b0;
      end else begin
         upd_done <= |sel;
         if (state == IDLE && in_valid) begin
            ch_q <= in_ch;
            en_q <= in_en;
            val_q <= in_value;
            bin_sh <= in_value;
            bcd_sh <= '0;
            cnt <= '0;
         end
         if (state == SHIFT) begin
            {bcd_sh, bin_sh} <= {adj[DW-2:0], bin_sh, 1'b0};
            cnt <= cnt + 1'b1;
         end
         for (int c = 0; c < NUM_CH; c++)
            if (sel[c]) begin
               bcd_out[c*DW +: DW] <= digits;
               ovf_out[c] <= en_q && sat;
               en_r[c] <= en_q;
               lo_r[c] <= en_q && lo;
            end
      end
   end
   always_ff @(posedge clk) flash_phase <= rst ? 1'b0 : flash_phase ^ flash_tick;
   // z tracks "this digit and every digit above it are zero", scanning from the top digit down.
   always_comb begin
      blank_out = '0;
      z = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         z = 1'b1;
         for (int d = DIGITS - 1; d >= 0; d--) begin
            z = z && bcd_out[(c*DIGITS+d)*4 +: 4] == 4'd0;
            blank_out[c*DIGITS+d] = !en_r[c] || (flash_phase && lo_r[c]) || (LZ_BLANK != 0 && d > 0 && z);
         end
      end
   end
endmodule
